// File: rtl/settings_bus_master.sv
// settings_bus_master
// Converts 64-bit command words into settings-bus transactions.
//   bit[63]=0 : write  -> one-cycle set_stb with registered set_addr/set_data
//   bit[63]=1 : read   -> rb_stb, wait RB_LATENCY cycles, sample rb_data and
//                         return it on the o_t* response stream
// Build option: define SETTINGS_BUS_MASTER_READBACK_EN to build the readback
// path. Without it, read commands are consumed and flagged on error_stb, and
// all readback/response outputs are tied to zero.
module settings_bus_master #(
  parameter int AWIDTH     = 8,
  parameter int RB_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic              set_stb,
  output logic [AWIDTH-1:0] set_addr,
  output logic [31:0]       set_data,
  output logic              rb_stb,
  output logic [AWIDTH-1:0] rb_addr,
  input  logic [63:0]       rb_data,
  output logic [63:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              error_stb
);

  localparam logic [3:0] RB_LAT_C = 4'(RB_LATENCY);

`ifdef SETTINGS_BUS_MASTER_READBACK_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RB_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;
`else
  // WRITE doubles as the one-cycle slot for the error pulse of a read.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
  } state_e;
`endif

  state_e            state_q, state_d;
  logic              i_tready_q, i_tready_d;
  logic              set_stb_q, set_stb_d;
  logic [AWIDTH-1:0] set_addr_q, set_addr_d;
  logic [31:0]       set_data_q, set_data_d;
  logic              error_stb_q, error_stb_d;
  logic              accept_s;
  logic              unused_s;

  assign accept_s = i_tvalid && i_tready_q;

`ifdef SETTINGS_BUS_MASTER_READBACK_EN
  logic              rb_stb_q, rb_stb_d;
  logic [AWIDTH-1:0] rb_addr_q, rb_addr_d;
  logic              cmd_tlast_q, cmd_tlast_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [63:0]       o_tdata_q, o_tdata_d;
  logic              o_tlast_q, o_tlast_d;
  logic              o_tvalid_q, o_tvalid_d;

  assign rb_stb   = rb_stb_q;
  assign rb_addr  = rb_addr_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;
  assign unused_s = ^{i_tdata[62:32]};
`else
  assign rb_stb   = 1'b0;
  assign rb_addr  = {AWIDTH{1'b0}};
  assign o_tdata  = 64'd0;
  assign o_tlast  = 1'b0;
  assign o_tvalid = 1'b0;
  assign unused_s = ^{i_tdata[62:32], i_tlast, rb_data, o_tready, RB_LAT_C};
`endif

  assign i_tready  = i_tready_q;
  assign set_stb   = set_stb_q;
  assign set_addr  = set_addr_q;
  assign set_data  = set_data_q;
  assign error_stb = error_stb_q;

  // Next-state and next-output logic; every registered output is computed here
  always_comb begin
    state_d     = state_q;
    i_tready_d  = 1'b0;
    set_stb_d   = 1'b0;
    set_addr_d  = set_addr_q;
    set_data_d  = set_data_q;
    error_stb_d = 1'b0;
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
    rb_stb_d    = 1'b0;
    rb_addr_d   = rb_addr_q;
    cmd_tlast_d = cmd_tlast_q;
    cnt_d       = cnt_q;
    o_tdata_d   = o_tdata_q;
    o_tlast_d   = o_tlast_q;
    o_tvalid_d  = o_tvalid_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s && i_tdata[63]) begin
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
          state_d     = RB_WAIT;
          rb_stb_d    = 1'b1;
          rb_addr_d   = i_tdata[32 +: AWIDTH];
          cmd_tlast_d = i_tlast;
          cnt_d       = 4'd0;
`else
          state_d     = WRITE;
          error_stb_d = 1'b1;
`endif
        end else if (accept_s) begin
          state_d    = WRITE;
          set_stb_d  = 1'b1;
          set_addr_d = i_tdata[32 +: AWIDTH];
          set_data_d = i_tdata[31:0];
        end else begin
          i_tready_d = 1'b1;
        end
      end
      WRITE: begin
        state_d    = IDLE;
        i_tready_d = 1'b1;
      end
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
      RB_WAIT: begin
        // cnt_q counts cycles since the rb_stb cycle (which has cnt_q == 0)
        if (cnt_q == RB_LAT_C) begin
          state_d    = RESP;
          o_tdata_d  = rb_data;
          o_tlast_d  = cmd_tlast_q;
          o_tvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (o_tready) begin
          state_d    = IDLE;
          o_tvalid_d = 1'b0;
          i_tready_d = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered command-side and write-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_tready_q  <= 1'b0;
      set_stb_q   <= 1'b0;
      set_addr_q  <= {AWIDTH{1'b0}};
      set_data_q  <= 32'd0;
      error_stb_q <= 1'b0;
    end else begin
      i_tready_q  <= i_tready_d;
      set_stb_q   <= set_stb_d;
      set_addr_q  <= set_addr_d;
      set_data_q  <= set_data_d;
      error_stb_q <= error_stb_d;
    end
  end

`ifdef SETTINGS_BUS_MASTER_READBACK_EN
  // Registered readback request and response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rb_stb_q    <= 1'b0;
      rb_addr_q   <= {AWIDTH{1'b0}};
      cmd_tlast_q <= 1'b0;
      cnt_q       <= 4'd0;
      o_tdata_q   <= 64'd0;
      o_tlast_q   <= 1'b0;
      o_tvalid_q  <= 1'b0;
    end else begin
      rb_stb_q    <= rb_stb_d;
      rb_addr_q   <= rb_addr_d;
      cmd_tlast_q <= cmd_tlast_d;
      cnt_q       <= cnt_d;
      o_tdata_q   <= o_tdata_d;
      o_tlast_q   <= o_tlast_d;
      o_tvalid_q  <= o_tvalid_d;
    end
  end
`endif

endmodule

// File: tb/tb_settings_bus_master.sv
// Testbench for settings_bus_master (AWIDTH=8, RB_LATENCY=2).
// A monitor turns DUT activity into a per-cycle event log; a reference model
// derives the expected event log from the accepted commands alone.
`timescale 1ns/1ps
module tb_settings_bus_master;
  localparam int AW  = 8;
  localparam int LAT = 2;
  localparam logic [2:0] K_SET = 3'd1, K_ERR = 3'd2, K_RB = 3'd3, K_RSP = 3'd4, K_RISE = 3'd5;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  kind;
    logic [63:0] val;
    logic        last;
  } ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [63:0] data;
    logic        last;
  } acc_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   i_tdata = 64'd0;
  logic          i_tlast = 1'b0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic          set_stb;
  logic [AW-1:0] set_addr;
  logic [31:0]   set_data;
  logic          rb_stb;
  logic [AW-1:0] rb_addr;
  logic [63:0]   rb_data = 64'd0;
  logic [63:0]   o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready = 1'b1;
  logic          error_stb;

  settings_bus_master #(.AWIDTH(AW), .RB_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rb_stb(rb_stb), .rb_addr(rb_addr), .rb_data(rb_data),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .error_stb(error_stb)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] rb_salt = 32'd0;
  bit          ordy_rand = 1'b0;
  logic        ordy_val = 1'b1;
  bit          ordy_hist [int];
  logic        prev_tready = 1'b0;
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  acc_t        acc_q[$];
  logic [63:0] cmd_q[$];
  logic        last_q[$];
  int          gap_q[$];

  // Monitor: drives readback-side inputs mid-cycle and logs DUT events
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      o_tready = ordy_rand ? 1'($urandom_range(0, 1)) : ordy_val;
      rb_data = {rb_salt, 32'(cyc)};
      ordy_hist[cyc] = o_tready;
      if (reset_n) begin
        if (i_tvalid && i_tready) acc_q.push_back({32'(cyc), i_tdata, i_tlast});
        if (set_stb) obs_q.push_back({32'(cyc), K_SET, {24'd0, set_addr, set_data}, 1'b0});
        if (error_stb) obs_q.push_back({32'(cyc), K_ERR, 64'd0, 1'b0});
        if (rb_stb) obs_q.push_back({32'(cyc), K_RB, {56'd0, rb_addr}, 1'b0});
        if (o_tvalid && o_tready) obs_q.push_back({32'(cyc), K_RSP, o_tdata, o_tlast});
        if (i_tready && !prev_tready) obs_q.push_back({32'(cyc), K_RISE, 64'd0, 1'b0});
      end
      prev_tready = i_tready;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: expected events from the accepted commands.
  // Write at N: strobe at N+1, ready again at N+2.
  // Read at N: rb_stb at N+1, data sampled at N+1+LAT, response transfers on
  // the first ready cycle after that, ready again the cycle after transfer.
  task automatic build_expected();
    exp_q.delete();
    foreach (acc_q[i]) begin
      int n;
      logic [63:0] d;
      n = int'(acc_q[i].cyc);
      d = acc_q[i].data;
      if (!d[63]) begin
        exp_q.push_back({32'(n + 1), K_SET, {24'd0, d[39:32], d[31:0]}, 1'b0});
        exp_q.push_back({32'(n + 2), K_RISE, 64'd0, 1'b0});
      end else begin
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
        int s;
        int c;
        s = n + 1 + LAT;
        c = s + 1;
        while (c < n + 1000 && !(ordy_hist.exists(c) && ordy_hist[c])) c++;
        exp_q.push_back({32'(n + 1), K_RB, {56'd0, d[39:32]}, 1'b0});
        exp_q.push_back({32'(c), K_RSP, {rb_salt, 32'(s)}, acc_q[i].last});
        exp_q.push_back({32'(c + 1), K_RISE, 64'd0, 1'b0});
`else
        exp_q.push_back({32'(n + 1), K_ERR, 64'd0, 1'b0});
        exp_q.push_back({32'(n + 2), K_RISE, 64'd0, 1'b0});
`endif
      end
    end
  endtask

  task automatic clear_logs();
    obs_q.delete();
    acc_q.delete();
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents queued commands; a zero gap keeps i_tvalid high into the next one
  task automatic drive_all();
    int guard;
    @(posedge clk);
    #1;
    while (cmd_q.size() > 0) begin
      if (gap_q[0] > 0) begin
        i_tvalid = 1'b0;
        repeat (gap_q[0]) begin
          @(posedge clk);
          #1;
        end
      end
      i_tdata  = cmd_q[0];
      i_tlast  = last_q[0];
      i_tvalid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!i_tready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (!i_tready) begin
        $display("FAIL accept_timeout: i_tready=%b after %0d cycles, required 1", i_tready, guard);
        fails++;
        cmd_q.delete();
        last_q.delete();
        gap_q.delete();
      end else begin
        void'(cmd_q.pop_front());
        void'(last_q.pop_front());
        void'(gap_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_tready, set_stb, rb_stb, o_tvalid, o_tlast, error_stb} !== 6'b0) begin
      $display("FAIL reset_flags: got %b required 000000",
               {i_tready, set_stb, rb_stb, o_tvalid, o_tlast, error_stb});
      fails++;
    end
    checks++;
    if (set_addr !== 8'h00 || set_data !== 32'h0 || rb_addr !== 8'h00 || o_tdata !== 64'h0) begin
      $display("FAIL reset_data: set_addr=%h set_data=%h rb_addr=%h o_tdata=%h required all 0",
               set_addr, set_data, rb_addr, o_tdata);
      fails++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i_tready !== 1'b0) begin
      $display("FAIL reset_tready_early: got %b required 0", i_tready);
      fails++;
    end
    @(negedge clk);
    checks++;
    if (i_tready !== 1'b1) begin
      $display("FAIL reset_tready_first_edge: got %b required 1", i_tready);
      fails++;
    end
    settle(1);
  endtask

  task automatic test_write_directed();
    clear_logs();
    cmd_q.push_back(64'h0000_0012_DEAD_BEEF);
    last_q.push_back(1'b1);
    gap_q.push_back(0);
    drive_all();
    settle(6);
    checks++;
    if (set_addr !== 8'h12 || set_data !== 32'hDEADBEEF) begin
      $display("FAIL wr_hold: set_addr=%h set_data=%h required 12 deadbeef", set_addr, set_data);
      fails++;
    end
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin
      $display("FAIL wr_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL wr_event%0d: got cyc=%0d kind=%0d val=%h last=%b required cyc=%0d kind=%0d val=%h last=%b",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, obs_q[i].last,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].last);
        fails++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] c;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      c = {$urandom, $urandom};
      c[63] = 1'b0;
      cmd_q.push_back(c);
      last_q.push_back(1'($urandom_range(0, 1)));
      gap_q.push_back(0);
    end
    drive_all();
    settle(6);
    checks++;
    if (acc_q.size() != 4) begin
      $display("FAIL b2b_accepts: got %0d required 4", acc_q.size());
      fails++;
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i].cyc - acc_q[i-1].cyc !== 32'd2) begin
        $display("FAIL b2b_spacing%0d: got %0d cycles required 2", i, acc_q[i].cyc - acc_q[i-1].cyc);
        fails++;
      end
    end
    checks++;
    if (set_addr !== c[39:32] || set_data !== c[31:0]) begin
      $display("FAIL b2b_hold: set_addr=%h set_data=%h required %h %h", set_addr, set_data, c[39:32], c[31:0]);
      fails++;
    end
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 8) begin
      $display("FAIL b2b_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL b2b_event%0d: got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
        fails++;
      end
    end
  endtask

`ifdef SETTINGS_BUS_MASTER_READBACK_EN
  task automatic test_read_backpressure();
    int guard;
    logic [63:0] want;
    clear_logs();
    rb_salt = $urandom;
    ordy_val = 1'b0;
    cmd_q.push_back(64'h8000_0034_0000_0000);
    last_q.push_back(1'b1);
    gap_q.push_back(0);
    drive_all();
    want = (acc_q.size() > 0) ? {rb_salt, 32'(int'(acc_q[0].cyc) + 1 + LAT)} : 64'd0;
    guard = 0;
    @(negedge clk);
    while (!o_tvalid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (o_tvalid !== 1'b1) begin
      $display("FAIL rd_valid: got %b required 1", o_tvalid);
      fails++;
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (o_tdata !== want || o_tlast !== 1'b1 || i_tready !== 1'b0 || rb_addr !== 8'h34 || o_tvalid !== 1'b1) begin
        $display("FAIL rd_hold%0d: o_tdata=%h o_tlast=%b i_tready=%b rb_addr=%h o_tvalid=%b required %h 1 0 34 1",
                 k, o_tdata, o_tlast, i_tready, rb_addr, o_tvalid, want);
        fails++;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ordy_val = 1'b1;
    settle(8);
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
      $display("FAIL rd_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL rd_event%0d: got cyc=%0d kind=%0d val=%h last=%b required cyc=%0d kind=%0d val=%h last=%b",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, obs_q[i].last,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].last);
        fails++;
      end
    end
  endtask
`else
  task automatic test_read_error();
    logic [63:0] c;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      c = {$urandom, $urandom};
      c[63] = 1'b1;
      cmd_q.push_back(c);
      last_q.push_back(1'($urandom_range(0, 1)));
      gap_q.push_back(i);
    end
    drive_all();
    settle(6);
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 6) begin
      $display("FAIL err_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL err_event%0d: got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
        fails++;
      end
    end
  endtask
`endif

  task automatic test_random_mix();
    logic [63:0] c;
    clear_logs();
    rb_salt = $urandom;
    for (int i = 0; i < 40; i++) begin
      c = {$urandom, $urandom};
      c[63] = ($urandom_range(0, 2) == 0);
      cmd_q.push_back(c);
      last_q.push_back(1'($urandom_range(0, 1)));
      gap_q.push_back($urandom_range(0, 3));
    end
    ordy_rand = 1'b1;
    drive_all();
    @(posedge clk);
    #1;
    ordy_rand = 1'b0;
    ordy_val = 1'b1;
    settle(20);
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      $display("FAIL mix_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL mix_event%0d: got cyc=%0d kind=%0d val=%h last=%b required cyc=%0d kind=%0d val=%h last=%b",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, obs_q[i].last,
                 exp_q[i].cyc, exp_q[i].kind, exp_q[i].val, exp_q[i].last);
        fails++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] c;
    clear_logs();
    c = {$urandom, $urandom};
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
    c[63] = 1'b1;
`else
    c[63] = 1'b0;
`endif
    cmd_q.push_back(c);
    last_q.push_back(1'b1);
    gap_q.push_back(0);
    drive_all();
    checks++;
    if ((set_stb | rb_stb) !== 1'b1) begin
      $display("FAIL mid_pending: set_stb=%b rb_stb=%b required one strobe high", set_stb, rb_stb);
      fails++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({i_tready, set_stb, rb_stb, o_tvalid, o_tlast, error_stb} !== 6'b0 ||
        set_addr !== 8'h00 || set_data !== 32'h0 || rb_addr !== 8'h00 || o_tdata !== 64'h0) begin
      $display("FAIL mid_reset: flags=%b set_addr=%h set_data=%h rb_addr=%h o_tdata=%h required all 0",
               {i_tready, set_stb, rb_stb, o_tvalid, o_tlast, error_stb}, set_addr, set_data, rb_addr, o_tdata);
      fails++;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    clear_logs();
    c = {$urandom, $urandom};
    c[63] = 1'b0;
    cmd_q.push_back(c);
    last_q.push_back(1'b0);
    gap_q.push_back(0);
    drive_all();
    settle(6);
    checks++;
    if (set_addr !== c[39:32] || set_data !== c[31:0]) begin
      $display("FAIL mid_write_hold: set_addr=%h set_data=%h required %h %h", set_addr, set_data, c[39:32], c[31:0]);
      fails++;
    end
    build_expected();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin
      $display("FAIL mid_count: %0d events observed, required %0d", obs_q.size(), exp_q.size());
      fails++;
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL mid_event%0d: got cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                 i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].val, exp_q[i].cyc, exp_q[i].kind, exp_q[i].val);
        fails++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_directed();
    test_back_to_back();
`ifdef SETTINGS_BUS_MASTER_READBACK_EN
    test_read_backpressure();
`else
    test_read_error();
`endif
    test_random_mix();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
